// File: rtl/banked_mem_ctrl.sv
// Registered load/store controller fanning one request port out to NUM_BANKS memory banks.
// Define BANKED_MEM_CTRL_ERR_EN to report unmapped selectors on rsp_err.
module banked_mem_ctrl #(
  parameter int                   NUM_BANKS   = 3,
  parameter int                   ADDR_W      = 16,
  parameter int                   BANK_ADDR_W = 12,
  parameter int                   DATA_W      = 32,
  parameter int                   RD_LAT      = 1,
  parameter logic [NUM_BANKS-1:0] NARROW_MASK = 3'b010
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_req_valid,
  output logic                        o_req_ready,
  input  logic                        i_req_we,
  input  logic [ADDR_W-1:0]           i_req_addr,
  input  logic [DATA_W-1:0]           i_req_wdata,
  input  logic [DATA_W/8-1:0]         i_req_be,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic [DATA_W-1:0]           o_rsp_rdata,
  output logic                        o_rsp_err,
  output logic [NUM_BANKS-1:0]        o_bank_wren,
  output logic [BANK_ADDR_W-1:0]      o_bank_addr,
  output logic [DATA_W-1:0]           o_bank_wdata,
  output logic [DATA_W/8-1:0]         o_bank_be,
  input  logic [NUM_BANKS*DATA_W-1:0] i_bank_rdata
);

  localparam int SEL_W = ADDR_W - BANK_ADDR_W;
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(RD_LAT + 1);

`ifdef BANKED_MEM_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  r_state;
  logic                    r_we;
  logic [NUM_BANKS-1:0]    r_hit;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_rsp_valid;
  logic [DATA_W-1:0]       r_rsp_rdata;
  logic                    r_rsp_err;
  logic [NUM_BANKS-1:0]    r_bank_wren;
  logic [BANK_ADDR_W-1:0]  r_bank_addr;
  logic [DATA_W-1:0]       r_bank_wdata;
  logic [BE_W-1:0]         r_bank_be;

  logic [SEL_W-1:0]        w_req_sel;
  logic [NUM_BANKS-1:0]    w_req_hit;
  logic                    w_req_narrow;
  logic [DATA_W-1:0]       w_bank_rd [NUM_BANKS];
  logic [DATA_W-1:0]       w_sel_rd;
  logic                    w_rd_narrow;
  logic [DATA_W-1:0]       w_rsp_data;

  assign w_req_sel = i_req_addr[ADDR_W-1:BANK_ADDR_W];

  // One-hot bank decode; a selector past the last bank leaves every bit clear.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    assign w_req_hit[gi] = (w_req_sel == SEL_W'(gi));
    assign w_bank_rd[gi] = i_bank_rdata[gi*DATA_W +: DATA_W];
  end

  assign w_req_narrow = |(w_req_hit & NARROW_MASK);
  assign w_rd_narrow  = |(r_hit & NARROW_MASK);

  always_comb begin
    w_sel_rd = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (r_hit[b]) w_sel_rd = w_bank_rd[b];
    end
  end

  assign w_rsp_data = (r_hit == '0) ? '0 :
                      w_rd_narrow   ? {BE_W{w_sel_rd[7:0]}} : w_sel_rd;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_hit        <= '0;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_bank_wren  <= '0;
      r_bank_addr  <= '0;
      r_bank_wdata <= '0;
      r_bank_be    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_we        <= i_req_we;
            r_hit       <= w_req_hit;
            r_bank_addr <= i_req_addr[BANK_ADDR_W-1:0];
            r_bank_wren <= i_req_we ? w_req_hit : '0;
            // Narrow banks only see byte lane 0.
            if (w_req_narrow) begin
              r_bank_wdata <= DATA_W'(i_req_wdata[7:0]);
              r_bank_be    <= BE_W'(i_req_be[0]);
            end else begin
              r_bank_wdata <= i_req_wdata;
              r_bank_be    <= i_req_be;
            end
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_bank_wren <= '0;
          if (r_we) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_err   <= ERR_EN && (r_hit == '0);
            r_state     <= RESP;
          end else begin
            r_cnt   <= CNT_W'(RD_LAT);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rsp_data;
            r_rsp_err   <= ERR_EN && (r_hit == '0);
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready  = (r_state == IDLE);
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_rdata  = r_rsp_rdata;
  assign o_rsp_err    = r_rsp_err;
  assign o_bank_wren  = r_bank_wren;
  assign o_bank_addr  = r_bank_addr;
  assign o_bank_wdata = r_bank_wdata;
  assign o_bank_be    = r_bank_be;

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Directed bench for banked_mem_ctrl: one DUT with RD_LAT=1 and a second with RD_LAT=3.
module tb_banked_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_we, rsp_ready;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [95:0] bank_rdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, bank_wdata;
  logic [2:0]  bank_wren;
  logic [11:0] bank_addr;
  logic [3:0]  bank_be;

  logic        req_valid3, req_we3, rsp_ready3;
  logic [15:0] req_addr3;
  logic [31:0] req_wdata3;
  logic [3:0]  req_be3;
  logic [95:0] bank_rdata3;
  logic        req_ready3, rsp_valid3, rsp_err3;
  logic [31:0] rsp_rdata3, bank_wdata3;
  logic [2:0]  bank_wren3;
  logic [11:0] bank_addr3;
  logic [3:0]  bank_be3;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef BANKED_MEM_CTRL_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  banked_mem_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_bank_wren(bank_wren), .o_bank_addr(bank_addr),
    .o_bank_wdata(bank_wdata), .o_bank_be(bank_be), .i_bank_rdata(bank_rdata)
  );

  banked_mem_ctrl #(.RD_LAT(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid3), .o_req_ready(req_ready3), .i_req_we(req_we3),
    .i_req_addr(req_addr3), .i_req_wdata(req_wdata3), .i_req_be(req_be3),
    .o_rsp_valid(rsp_valid3), .i_rsp_ready(rsp_ready3),
    .o_rsp_rdata(rsp_rdata3), .o_rsp_err(rsp_err3),
    .o_bank_wren(bank_wren3), .o_bank_addr(bank_addr3),
    .o_bank_wdata(bank_wdata3), .o_bank_be(bank_be3), .i_bank_rdata(bank_rdata3)
  );

  // Presents one request while the DUT is idle; it is accepted on the next rising edge.
  task automatic send(input logic we, input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    $display("txn we=%0d addr=%h wdata=%h be=%b", we, a, d, be);
  endtask

  // Observes cycles first..8 after accept: first rsp_valid cycle, its data/err, and wren activity.
  task automatic wait_rsp(input int first, output int vc, output logic [31:0] d, output logic e,
                          output int nw, output logic [2:0] wseen);
    vc = 0; d = '0; e = 1'b0; nw = 0; wseen = '0;
    for (int c = first; c <= 8; c++) begin
      @(negedge clk);
      if (bank_wren != 3'b000) begin nw++; wseen |= bank_wren; end
      if (rsp_valid && vc == 0) begin vc = c; d = rsp_rdata; e = rsp_err; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b exp=1", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else n_pass++;
    n_checks++; if ({rsp_err, rsp_rdata} !== 33'h0) $display("FAIL reset_rsp got=%b/%h exp=0/0", rsp_err, rsp_rdata); else n_pass++;
    n_checks++; if ({bank_wren, bank_addr, bank_wdata, bank_be} !== 51'h0)
      $display("FAIL reset_bank got=%b/%h/%h/%b exp=all zero", bank_wren, bank_addr, bank_wdata, bank_be); else n_pass++;
    rst_n = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_write_wide();
    rsp_ready = 1'b1;
    send(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    n_checks++; if (bank_wren !== 3'b001) $display("FAIL wr_wren got=%b exp=001", bank_wren); else n_pass++;
    n_checks++; if (bank_addr !== 12'h010) $display("FAIL wr_addr got=%h exp=010", bank_addr); else n_pass++;
    n_checks++; if ({bank_wdata, bank_be} !== {32'hDEADBEEF, 4'hF})
      $display("FAIL wr_data_be got=%h/%b exp=deadbeef/1111", bank_wdata, bank_be); else n_pass++;
    @(negedge clk);
    n_checks++; if ({rsp_valid, req_ready, bank_wren} !== 5'b10000)
      $display("FAIL wr_cycle2 got valid=%b ready=%b wren=%b exp 1/0/000", rsp_valid, req_ready, bank_wren); else n_pass++;
    n_checks++; if ({rsp_err, rsp_rdata} !== 33'h0) $display("FAIL wr_rsp got=%b/%h exp=0/0", rsp_err, rsp_rdata); else n_pass++;
    @(negedge clk);
    n_checks++; if ({rsp_valid, req_ready} !== 2'b01)
      $display("FAIL wr_cycle3 got valid=%b ready=%b exp 0/1", rsp_valid, req_ready); else n_pass++;
  endtask

  task automatic test_read_wide();
    int vc, nw; logic [31:0] d; logic e; logic [2:0] ws;
    send(1'b0, 16'h0010, 32'h0, 4'h0);
    wait_rsp(1, vc, d, e, nw, ws);
    n_checks++; if (vc !== 3) $display("FAIL rd_latency got=%0d exp=3", vc); else n_pass++;
    n_checks++; if ({e, d} !== {1'b0, 32'hDEADBEEF}) $display("FAIL rd_data got=%b/%h exp=0/deadbeef", e, d); else n_pass++;
    n_checks++; if (nw !== 0) $display("FAIL rd_no_wren got=%0d exp=0", nw); else n_pass++;
  endtask

  task automatic test_rdlat3();
    int vc;
    logic [31:0] d;
    vc = 0; d = '0;
    @(negedge clk);
    req_we3 = 1'b0; req_addr3 = 16'h0010; req_valid3 = 1'b1;
    @(posedge clk);
    #1 req_valid3 = 1'b0;
    $display("txn lat3 read addr=%h", req_addr3);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++; if (bank_addr3 !== 12'h010) $display("FAIL lat3_addr got=%h exp=010", bank_addr3); else n_pass++;
      end
      if (rsp_valid3 && vc == 0) begin vc = c; d = rsp_rdata3; end
    end
    n_checks++; if (vc !== 5) $display("FAIL lat3_latency got=%0d exp=5", vc); else n_pass++;
    n_checks++; if (d !== 32'hCAFEF00D) $display("FAIL lat3_data got=%h exp=cafef00d", d); else n_pass++;
  endtask

  task automatic test_narrow();
    int vc, nw; logic [31:0] d; logic e; logic [2:0] ws;
    send(1'b1, 16'h1004, 32'h5A5A5AA5, 4'hF);
    @(negedge clk);
    n_checks++; if (bank_wren !== 3'b010) $display("FAIL nar_wren got=%b exp=010", bank_wren); else n_pass++;
    n_checks++; if ({bank_wdata, bank_be} !== {32'h000000A5, 4'b0001})
      $display("FAIL nar_data_be got=%h/%b exp=000000a5/0001", bank_wdata, bank_be); else n_pass++;
    n_checks++; if (bank_addr !== 12'h004) $display("FAIL nar_addr got=%h exp=004", bank_addr); else n_pass++;
    wait_rsp(2, vc, d, e, nw, ws);
    n_checks++; if (vc !== 2) $display("FAIL nar_wr_latency got=%0d exp=2", vc); else n_pass++;
    send(1'b0, 16'h1004, 32'h0, 4'h0);
    wait_rsp(1, vc, d, e, nw, ws);
    n_checks++; if (vc !== 3) $display("FAIL nar_rd_latency got=%0d exp=3", vc); else n_pass++;
    n_checks++; if (d !== 32'hA5A5A5A5) $display("FAIL nar_rd_data got=%h exp=a5a5a5a5", d); else n_pass++;
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    send(1'b1, 16'h2000, 32'h11223344, 4'b0100);
    @(negedge clk);
    n_checks++; if ({bank_wren, bank_be} !== {3'b100, 4'b0100})
      $display("FAIL bp_wren_be got=%b/%b exp=100/0100", bank_wren, bank_be); else n_pass++;
    n_checks++; if (bank_wdata !== 32'h11223344) $display("FAIL bp_wdata got=%h exp=11223344", bank_wdata); else n_pass++;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid_rise got=%b exp=1", rsp_valid); else n_pass++;
    req_we = 1'b0; req_addr = 16'h0010; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if ({rsp_valid, req_ready, bank_wren} !== 5'b10000)
        $display("FAIL bp_hold%0d got valid=%b ready=%b wren=%b exp 1/0/000", i, rsp_valid, req_ready, bank_wren); else n_pass++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({rsp_valid, req_ready} !== 2'b01)
      $display("FAIL bp_release got valid=%b ready=%b exp 0/1", rsp_valid, req_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if ({req_ready, bank_addr} !== {1'b1, 12'h000})
      $display("FAIL bp_not_accepted got ready=%b addr=%h exp 1/000", req_ready, bank_addr); else n_pass++;
  endtask

  task automatic test_unmapped();
    int vc, nw; logic [31:0] d; logic e; logic [2:0] ws;
    send(1'b1, 16'h3000, 32'hFFFFFFFF, 4'hF);
    wait_rsp(1, vc, d, e, nw, ws);
    n_checks++; if (ws !== 3'b000) $display("FAIL um_wr_wren got=%b exp=000", ws); else n_pass++;
    n_checks++; if (vc !== 2) $display("FAIL um_wr_latency got=%0d exp=2", vc); else n_pass++;
    n_checks++; if ({e, d} !== {EXP_ERR, 32'h0}) $display("FAIL um_wr_rsp got=%b/%h exp=%b/0", e, d, EXP_ERR); else n_pass++;
    send(1'b0, 16'h3000, 32'h0, 4'h0);
    wait_rsp(1, vc, d, e, nw, ws);
    n_checks++; if (vc !== 3) $display("FAIL um_rd_latency got=%0d exp=3", vc); else n_pass++;
    n_checks++; if ({e, d} !== {EXP_ERR, 32'h0}) $display("FAIL um_rd_rsp got=%b/%h exp=%b/0", e, d, EXP_ERR); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int vc, nw; logic [31:0] d; logic e; logic [2:0] ws;
    logic seen_valid;
    send(1'b0, 16'h2123, 32'h0, 4'h0);
    wait_rsp(1, vc, d, e, nw, ws);
    n_checks++; if ({vc == 3, d} !== {1'b1, 32'h0BADF00D}) $display("FAIL rm_pre_read got=%0d/%h exp=3/0badf00d", vc, d); else n_pass++;
    send(1'b0, 16'h2123, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if ({rsp_valid, req_ready, rsp_err} !== 3'b010)
      $display("FAIL rm_async_ctrl got valid=%b ready=%b err=%b exp 0/1/0", rsp_valid, req_ready, rsp_err); else n_pass++;
    n_checks++; if ({rsp_rdata, bank_addr} !== 44'h0) $display("FAIL rm_async_data got=%h/%h exp=0/0", rsp_rdata, bank_addr); else n_pass++;
    seen_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen_valid |= rsp_valid;
    end
    n_checks++; if (seen_valid !== 1'b0) $display("FAIL rm_no_valid got=%b exp=0", seen_valid); else n_pass++;
    rst_n = 1'b1;
    send(1'b1, 16'h0020, 32'h12345678, 4'hF);
    @(negedge clk);
    n_checks++; if (bank_wren !== 3'b001) $display("FAIL rm_wr_wren got=%b exp=001", bank_wren); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bank_wren, bank_wdata, bank_be} !== 39'h0)
      $display("FAIL rm_wren_async got=%b/%h/%b exp=0", bank_wren, bank_wdata, bank_be); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn reset released after mid-operation reset");
    send(1'b0, 16'h0010, 32'h0, 4'h0);
    wait_rsp(1, vc, d, e, nw, ws);
    n_checks++; if (vc !== 3) $display("FAIL rm_post_latency got=%0d exp=3", vc); else n_pass++;
    n_checks++; if (d !== 32'hDEADBEEF) $display("FAIL rm_post_data got=%h exp=deadbeef", d); else n_pass++;
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
    req_valid3 = 1'b0; req_we3 = 1'b0; req_addr3 = '0; req_wdata3 = '0; req_be3 = '0; rsp_ready3 = 1'b1;
    bank_rdata  = {32'h0BADF00D, 32'hFFFFFFA5, 32'hDEADBEEF};
    bank_rdata3 = {32'h0BADF00D, 32'hFFFFFFA5, 32'hCAFEF00D};
    test_reset();
    test_write_wide();
    test_read_wide();
    test_rdlat3();
    test_narrow();
    test_backpressure();
    test_unmapped();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/banked_mem_ctrl.md
# banked_mem_ctrl

Parametrised, registered memory controller between the processor's 32-bit load/store port and NUM_BANKS on-chip data-memory banks. It decodes the upper address bits to a bank, drives that bank's write enable, address, data and byte enables, and returns read data after the bank's read latency. A valid/ready request channel and a valid/ready response channel replace direct combinational muxing. It supports per-byte write strobes and narrow (8-bit) banks.

## Interface
- NUM_BANKS, 3: number of banks; selector values 0..NUM_BANKS-1 are mapped.
- ADDR_W, 16: request address width.
- BANK_ADDR_W, 12: in-bank word address width; selector = req_addr[ADDR_W-1:BANK_ADDR_W].
- DATA_W, 32: data width, a multiple of 8.
- RD_LAT, 1: bank read latency in cycles, at least 1.
- NARROW_MASK, 3'b010: bit b=1 marks bank b as 8 bits wide.

- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  byte-free word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  write byte enables.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  unmapped selector (see Configuration).
- bank_wren  out  NUM_BANKS  one-hot write enable.
- bank_addr  out  BANK_ADDR_W  shared bank address.
- bank_wdata  out  DATA_W  shared write data.
- bank_be  out  DATA_W/8  shared byte enables.
- bank_rdata  in  NUM_BANKS*DATA_W  bank b occupies bits [b*DATA_W +: DATA_W]; narrow banks use only the low 8 bits.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we, selector, address, data and be, then go to ISSUE.
  - ISSUE (1 cycle): bank_addr, bank_wdata and bank_be are driven.
    - On a mapped write, bank_wren[sel]=1 for this cycle only, then go to RESP.
    - On a read, load the latency counter with RD_LAT and go to WAIT.
  - WAIT (RD_LAT cycles): bank_addr is held. In the final WAIT cycle the controller captures the selected bank's read data into rsp_rdata, then goes to RESP.
  - RESP: rsp_valid=1, and rsp_rdata/rsp_err are held stable. On rsp_ready, go to IDLE.
- Only one request is outstanding at a time. req_ready is 0 in every state except IDLE.
- Narrow bank reads: rsp_rdata = the low byte replicated into all DATA_W/8 lanes.
- Narrow bank writes: bank_wdata lane 0 = req_wdata[7:0], and bank_be = {0,…,req_be[0]}.
- Wide banks pass bank_wdata and bank_be through unchanged.
- If req_be is all-zero on a write, the bank still sees a wren pulse with be=0 and no data changes. A response is still returned.
- Reset values: FSM=IDLE, req_ready=1 (its combinational value from IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, bank_wren=0, bank_addr=0, bank_wdata=0, bank_be=0.
- Reset mid-operation: all state clears immediately, bank_wren falls asynchronously, and any pending response is discarded.

## Timing
- Request accepted on edge 0:
  - Write: bank_wren is high in cycle 1, and rsp_valid rises in cycle 2.
  - Read: the address is driven from cycle 1, data is captured at the end of cycle 1+RD_LAT, and rsp_valid rises in cycle 2+RD_LAT. With RD_LAT=1, rsp_valid rises in cycle 3.
- If rsp_ready=1 in the first RESP cycle, req_ready is 1 in the next cycle.
- Minimum spacing between accepted requests:
  - 3 cycles for writes.
  - 3+RD_LAT cycles for reads.
- All bank-side outputs are registered, with no combinational path from req_* to bank_*.

## Configuration
- BANKED_MEM_CTRL_ERR_EN defined:
  - A selector ≥ NUM_BANKS never asserts any bank_wren.
  - Such a request responds with rsp_err=1 and rsp_rdata=0 after the same latency as a mapped access.
- BANKED_MEM_CTRL_ERR_EN undefined:
  - rsp_err is tied to 0.
  - Unmapped writes are silently dropped (no wren).
  - Unmapped reads return 0.
  - Latency is unchanged in both cases.

## Test plan
- Reset, then write 0xDEADBEEF with be=4'hF at 0x0010. Required: bank_wren=3'b001 for exactly one cycle, bank_addr=0x010, rsp_valid rises 2 cycles after accept, rsp_err=0.
- Read 0x0010 with bank 0 returning 0xDEADBEEF. Required: rsp_rdata=0xDEADBEEF with rsp_valid 3 cycles after accept (RD_LAT=1). Repeat with RD_LAT=3: rsp_valid must rise after 5 cycles.
- Write 0x000000A5 to 0x1004 (narrow bank 1). Required: bank_be=4'b0001. A subsequent read with bank 1 returning 0x..A5 must give rsp_rdata=0xA5A5A5A5.
- Write with be=4'b0100 to 0x2000. Required: bank_wren=3'b100 and bank_be=4'b0100. Hold rsp_ready=0 for 4 cycles: rsp_valid stays 1, req_ready stays 0, and a new req_valid is not accepted.
- Access 0x3000. With ERR_EN: no wren, rsp_err=1, rsp_rdata=0. Without ERR_EN: rsp_err=0, rsp_rdata=0.
- Deassert rst_n during WAIT. Required: rsp_valid never rises, all outputs return to their reset values immediately, and after release a fresh read completes normally.
